execute_stage_p: RTL and testbench

- Parametrised ID/EX pipeline register plus execute datapath for the pipelined CPU.
- Latches decoded operands and control flags, then applies MEM/WB forwarding and selects register or immediate for operand B.
- Computes single-cycle ALU results.
- Runs an iterative multi-cycle multiply FSM that back-pressures the front end through `busy`.

---
 rtl/exec_pkg.sv | 22 ++
 rtl/execute_stage_p_seq_multiplier.sv | 73 +++++++
 rtl/register.sv | 17 +
 rtl/execute_stage_p.sv | 144 ++++++++++++++
 tb/tb_execute_stage_p.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared opcode, forward-select and multiply-FSM definitions for the execute stage.
package exec_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/execute_stage_p_seq_multiplier.sv
// Iterative shift-add multiplier: start captures operands, done holds the low
// WIDTH product bits until ack.
module seq_multiplier
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             ack,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  mul_state_e       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state   <= ST_IDLE;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand   <= a;
            mplr    <= b;
            product <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mplr[0]) product <= product + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ack) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/register.sv
// Generic enabled register with asynchronous active-low clear.
module register #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/execute_stage_p.sv
// ID/EX stage register plus execute datapath with MEM/WB forwarding.
// Define EXEC_MUL_EN to build the iterative multiplier for opcode 110.
module execute_stage_p
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned RA_W        = 4,
  parameter int unsigned FLAGS_W     = 8,
  parameter int unsigned ALU_SRC_BIT = 3,
  parameter int unsigned REG_WR_BIT  = 5
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               stall_in,
  input  logic               flush,
  input  logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   imm,
  input  logic [WIDTH-1:0]   bus_a,
  input  logic [WIDTH-1:0]   bus_b,
  input  logic [RA_W-1:0]    rd_in,
  input  logic [FLAGS_W-1:0] cu_flags_in,
  input  logic [1:0]         fwd_sel_a,
  input  logic [1:0]         fwd_sel_b,
  input  logic [WIDTH-1:0]   fwd_mem_data,
  input  logic [WIDTH-1:0]   fwd_wb_data,
  output logic [WIDTH-1:0]   alu_out,
  output logic [WIDTH-1:0]   bus_b_out,
  output logic [RA_W-1:0]    rd_out,
  output logic [FLAGS_W-1:0] cu_flags_out,
  output logic               reg_wr,
  output logic               zero_flag,
  output logic               negative_flag,
  output logic               busy
);

  localparam int unsigned SH_W    = $clog2(WIDTH);
  localparam int unsigned STAGE_W = 3 + 3 * WIDTH + RA_W + FLAGS_W;

  logic [STAGE_W-1:0] stage_d;
  logic [STAGE_W-1:0] stage_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   imm_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [RA_W-1:0]    rd_q;
  logic [FLAGS_W-1:0] flags_q;
  logic               stage_en;
  logic               hold;
  logic               mul_mask;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_res;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   alu_c;

  assign stage_en = ~stall_in & ~hold;
  assign stage_d  = flush ? '0 : {alu_op, imm, bus_a, bus_b, rd_in, cu_flags_in};

  register #(.WIDTH(STAGE_W)) u_stage (
    .clk   (clk),
    .clear (clear),
    .en    (stage_en),
    .d     (stage_d),
    .q     (stage_q)
  );

  assign {op_q, imm_q, a_q, b_q, rd_q, flags_q} = stage_q;

  always_comb begin
    op_a = a_q;
    case (fwd_sel_a)
      FWD_MEM: op_a = fwd_mem_data;
      FWD_WB:  op_a = fwd_wb_data;
      default: op_a = a_q;
    endcase
  end

  always_comb begin
    bus_b_out = b_q;
    case (fwd_sel_b)
      FWD_MEM: bus_b_out = fwd_mem_data;
      FWD_WB:  bus_b_out = fwd_wb_data;
      default: bus_b_out = b_q;
    endcase
  end

  assign op_b = flags_q[ALU_SRC_BIT] ? imm_q : bus_b_out;

`ifdef EXEC_MUL_EN
  logic mul_busy;
  logic mul_start;

  // The stage also holds on the start edge so the MUL keeps its rd/flags until DONE.
  assign mul_start = (op_q == OP_MUL) & ~mul_busy & ~mul_done;
  assign mul_mask  = (op_q == OP_MUL) & ~mul_done;
  assign hold      = mul_mask;
  assign busy      = mul_busy;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .clear   (clear),
    .start   (mul_start),
    .ack     (stage_en),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_res)
  );
`else
  assign hold     = 1'b0;
  assign busy     = 1'b0;
  assign mul_mask = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
`endif

  always_comb begin
    alu_c = '0;
    case (op_q)
      OP_AND:  alu_c = op_a & op_b;
      OP_ADD:  alu_c = op_a + op_b;
      OP_SUB:  alu_c = op_a - op_b;
      OP_OR:   alu_c = op_a | op_b;
      OP_SLL:  alu_c = op_a << op_b[SH_W-1:0];
      OP_SRL:  alu_c = op_a >> op_b[SH_W-1:0];
      OP_MUL:  alu_c = mul_done ? mul_res : '0;
      default: alu_c = '0;
    endcase
  end

  // Pending multiply looks like a bubble to MEM until its result is ready.
  always_comb begin
    cu_flags_out = flags_q;
    if (mul_mask) cu_flags_out[REG_WR_BIT] = 1'b0;
  end

  assign alu_out       = alu_c;
  assign rd_out        = rd_q;
  assign reg_wr        = cu_flags_out[REG_WR_BIT];
  assign zero_flag     = (alu_c == '0);
  assign negative_flag = alu_c[WIDTH-1];

endmodule

// File: tb/tb_execute_stage_p.sv
// Scoreboard bench for execute_stage_p; expectations follow EXEC_MUL_EN when defined.
module tb_execute_stage_p;
  import exec_pkg::*;

  logic        clk;
  logic        clear;
  logic        stall_in;
  logic        flush;
  logic [2:0]  alu_op;
  logic [31:0] imm;
  logic [31:0] bus_a;
  logic [31:0] bus_b;
  logic [3:0]  rd_in;
  logic [7:0]  cu_flags_in;
  logic [1:0]  fwd_sel_a;
  logic [1:0]  fwd_sel_b;
  logic [31:0] fwd_mem_data;
  logic [31:0] fwd_wb_data;
  logic [31:0] alu_out;
  logic [31:0] bus_b_out;
  logic [3:0]  rd_out;
  logic [7:0]  cu_flags_out;
  logic        reg_wr;
  logic        zero_flag;
  logic        negative_flag;
  logic        busy;

  execute_stage_p dut (
    .clk           (clk),
    .clear         (clear),
    .stall_in      (stall_in),
    .flush         (flush),
    .alu_op        (alu_op),
    .imm           (imm),
    .bus_a         (bus_a),
    .bus_b         (bus_b),
    .rd_in         (rd_in),
    .cu_flags_in   (cu_flags_in),
    .fwd_sel_a     (fwd_sel_a),
    .fwd_sel_b     (fwd_sel_b),
    .fwd_mem_data  (fwd_mem_data),
    .fwd_wb_data   (fwd_wb_data),
    .alu_out       (alu_out),
    .bus_b_out     (bus_b_out),
    .rd_out        (rd_out),
    .cu_flags_out  (cu_flags_out),
    .reg_wr        (reg_wr),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag),
    .busy          (busy)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [79:0] vec;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   ntests = 0;
  int   nfail = 0;
  logic stim_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input string nm, input logic [31:0] e_alu,
                           input logic [31:0] e_bbo, input logic [3:0] e_rd,
                           input logic [7:0] e_fl, input logic e_busy);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.vec  = {e_alu, e_bbo, e_rd, e_fl, e_fl[5], (e_alu == 32'd0), e_alu[31], e_busy};
    q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [3:0] rd, input logic [7:0] fl);
    alu_op = op; bus_a = a; bus_b = b; imm = im; rd_in = rd; cu_flags_in = fl;
  endtask

  task automatic fwd(input logic [1:0] sa, input logic [1:0] sb,
                     input logic [31:0] mem, input logic [31:0] wb);
    fwd_sel_a = sa; fwd_sel_b = sb; fwd_mem_data = mem; fwd_wb_data = wb;
  endtask

  // Instruction captured on one edge; forwarding applied while it sits in the stage.
  task automatic step(input string nm, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] im, input logic [3:0] rd,
                      input logic [7:0] fl, input logic [1:0] sa, input logic [1:0] sb,
                      input logic [31:0] mem, input logic [31:0] wb,
                      input logic [31:0] e_alu, input logic [31:0] e_bbo);
    tick();
    drive(op, a, b, im, rd, fl);
    tick();
    fwd(sa, sb, mem, wb);
    expect_at(cyc, nm, e_alu, e_bbo, rd, fl, 1'b0);
  endtask

  // Monitor: compares every expectation due on this cycle against the outputs.
  initial begin : monitor
    exp_t        e;
    logic [79:0] got;
    while (!stim_done) begin
      @(negedge clk);
      got = {alu_out, bus_b_out, rd_out, cu_flags_out, reg_wr, zero_flag, negative_flag, busy};
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        ntests++;
        if (e.cyc != cyc || got !== e.vec) begin
          nfail++;
          $display("FAIL %s cyc=%0d: got alu=%h bbo=%h rd=%h fl=%h wr/z/n/busy=%b, want alu=%h bbo=%h rd=%h fl=%h wr/z/n/busy=%b",
                   e.name, cyc, got[79:48], got[47:16], got[15:12], got[11:4], got[3:0],
                   e.vec[79:48], e.vec[47:16], e.vec[15:12], e.vec[11:4], e.vec[3:0]);
        end
      end
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      ntests++;
      nfail++;
      $display("FAIL %s never checked: got none, want check at cyc %0d", e.name, e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0;
    clear = 1'b0; stall_in = 1'b0; flush = 1'b0;
    drive(OP_AND, 32'd0, 32'd0, 32'd0, 4'd0, 8'h00);
    fwd(FWD_REG, FWD_REG, 32'd0, 32'd0);
    tick();
    expect_at(cyc, "reset", 32'd0, 32'd0, 4'd0, 8'h00, 1'b0);
    ntests++;
    if (zero_flag !== 1'b1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_direct: got zero=%b busy=%b, want zero=1 busy=0", zero_flag, busy);
    end
    tick();
    clear = 1'b1;

    step("add", OP_ADD, 32'd5, 32'd7, 32'd0, 4'd3, 8'h20, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd12, 32'd7);
    ntests++;
    if (alu_out !== 32'd12 || reg_wr !== 1'b1) begin
      nfail++;
      $display("FAIL add_direct: got alu=%h wr=%b, want alu=0000000c wr=1", alu_out, reg_wr);
    end
    step("fwd_mem_imm", OP_ADD, 32'd1, 32'h55, 32'd3, 4'd4, 8'h28, FWD_MEM, FWD_REG, 32'h10, 32'd0, 32'h13, 32'h55);
    step("fwd_wb_or", OP_OR, 32'h0F, 32'h1, 32'd0, 4'd5, 8'h20, FWD_REG, FWD_WB, 32'd0, 32'hF0, 32'hFF, 32'hF0);
    step("fwd_sel11_and", OP_AND, 32'hFF, 32'h0F, 32'd0, 4'd6, 8'h20, 2'b11, FWD_REG, 32'h1, 32'd0, 32'h0F, 32'h0F);
    step("sub", OP_SUB, 32'd9, 32'd4, 32'd0, 4'd7, 8'h20, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd5, 32'd4);
    step("sub_zero", OP_SUB, 32'd3, 32'd3, 32'd0, 4'd8, 8'h20, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd0, 32'd3);
    ntests++;
    if (zero_flag !== 1'b1) begin
      nfail++;
      $display("FAIL sub_zero_direct: got zero=%b, want zero=1", zero_flag);
    end
    step("sll_33", OP_SLL, 32'd1, 32'd0, 32'd33, 4'd9, 8'h28, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd2, 32'd0);
    step("srl", OP_SRL, 32'h8000_0000, 32'd4, 32'd0, 4'd10, 8'h20, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'h0800_0000, 32'd4);
    step("sub_neg", OP_SUB, 32'd0, 32'd1, 32'd0, 4'd11, 8'h20, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1);
    step("reserved", 3'b111, 32'd5, 32'd6, 32'd0, 4'd12, 8'h20, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd0, 32'd6);

    // Stall holds the stage, then a flush loads a bubble.
    step("pre_stall", OP_ADD, 32'd2, 32'd3, 32'd0, 4'd2, 8'h20, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd5, 32'd3);
    tick();
    stall_in = 1'b1;
    drive(OP_SUB, 32'd100, 32'd1, 32'd0, 4'd9, 8'h20);
    for (int i = 0; i < 4; i++) expect_at(cyc + i, "stall_hold", 32'd5, 32'd3, 4'd2, 8'h20, 1'b0);
    repeat (3) tick();
    stall_in = 1'b0;
    flush = 1'b1;
    expect_at(cyc + 1, "flush", 32'd0, 32'd0, 4'd0, 8'h00, 1'b0);
    tick();
    flush = 1'b0;
    ntests++;
    if (cu_flags_out !== 8'h00 || reg_wr !== 1'b0 || alu_out !== 32'd0) begin
      nfail++;
      $display("FAIL flush_direct: got fl=%h wr=%b alu=%h, want fl=00 wr=0 alu=00000000",
               cu_flags_out, reg_wr, alu_out);
    end

`ifdef EXEC_MUL_EN
    // 0x1234 via MEM forward times 0x100; later fwd changes must not matter.
    tick();
    drive(OP_MUL, 32'd0, 32'h100, 32'd0, 4'd6, 8'h20);
    fwd(FWD_MEM, FWD_REG, 32'h1234, 32'd0);
    tick();
    c0 = cyc;
    expect_at(c0, "mul_start", 32'd0, 32'h100, 4'd6, 8'h00, 1'b0);
    drive(OP_SUB, 32'd9, 32'd4, 32'd0, 4'd7, 8'h20);
    tick();
    fwd(FWD_REG, FWD_REG, 32'hDEAD, 32'd0);
    for (int i = 1; i <= 32; i++) expect_at(c0 + i, "mul_busy", 32'd0, 32'h100, 4'd6, 8'h00, 1'b1);
    expect_at(c0 + 33, "mul_done", 32'h0012_3400, 32'h100, 4'd6, 8'h20, 1'b0);
    expect_at(c0 + 34, "mul_next_sub", 32'd5, 32'd4, 4'd7, 8'h20, 1'b0);
    repeat (33) tick();

    tick();
    drive(OP_MUL, 32'hFFFF_FFFF, 32'd0, 32'd2, 4'd13, 8'h28);
    tick();
    c0 = cyc;
    drive(OP_AND, 32'd0, 32'd0, 32'd0, 4'd0, 8'h00);
    expect_at(c0 + 16, "mul2_busy", 32'd0, 32'd0, 4'd13, 8'h08, 1'b1);
    expect_at(c0 + 33, "mul2_done", 32'hFFFF_FFFE, 32'd0, 4'd13, 8'h28, 1'b0);
    expect_at(c0 + 34, "mul2_next", 32'd0, 32'd0, 4'd0, 8'h00, 1'b0);
    repeat (34) tick();
`else
    step("mul_reserved", OP_MUL, 32'h1234, 32'h100, 32'd0, 4'd6, 8'h20, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd0, 32'h100);
    expect_at(cyc + 1, "mul_no_busy1", 32'd0, 32'h100, 4'd6, 8'h20, 1'b0);
    expect_at(cyc + 2, "mul_no_busy2", 32'd0, 32'h100, 4'd6, 8'h20, 1'b0);
    repeat (2) tick();
    step("mul2_reserved", OP_MUL, 32'hFFFF_FFFF, 32'd0, 32'd2, 4'd13, 8'h28, FWD_REG, FWD_REG, 32'd0, 32'd0, 32'd0, 32'd0);
`endif

    // Reset ten cycles into a multiply, then resume with ADD 5+7.
    tick();
    drive(OP_MUL, 32'h1234, 32'h100, 32'd0, 4'd6, 8'h20);
    tick();
    c0 = cyc;
    repeat (10) tick();
    clear = 1'b0;
    expect_at(c0 + 10, "rst_mid_mul", 32'd0, 32'd0, 4'd0, 8'h00, 1'b0);
    drive(OP_ADD, 32'd5, 32'd7, 32'd0, 4'd3, 8'h20);
    tick();
    clear = 1'b1;
    expect_at(c0 + 11, "post_rst_idle", 32'd0, 32'd0, 4'd0, 8'h00, 1'b0);
    for (int i = 12; i <= 14; i++) expect_at(c0 + i, "post_rst_add", 32'd12, 32'd7, 4'd3, 8'h20, 1'b0);
    repeat (5) tick();
    stim_done = 1'b1;
  end

endmodule
